// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory slave with wait states, ready strobe and error response.
// Optional read-only free-running cycle counter at the top address when MEM_TIMER_EN is defined.
module mem_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  oe_mem,
    output logic                  mem_ready,
    output logic                  mem_err
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_wcnt;
    logic [IDXW-1:0] r_idx;
    logic [31:0]     r_wdata;
    logic            r_is_rd;
    logic            r_is_err;
    logic            r_is_tmr;

    logic [31:0]     r_data_out;
    logic            r_oe;
    logic            r_ready;
    logic            r_err_o;

    logic            w_req;
    logic            w_acc_tmr;
    logic            w_acc_err;
    logic            w_enter_resp;
    logic [IDXW-1:0] w_cur_idx;
    logic [31:0]     w_cur_wdata;
    logic            w_cur_rd;
    logic            w_cur_err;
    logic            w_cur_tmr;
    logic [31:0]     w_rd_word;

    logic [31:0]     r_mem [DEPTH];

    assign w_req = mem_rd | mem_wr;

`ifdef MEM_TIMER_EN
    logic [31:0] r_timer;

    // Free-running cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= 32'd0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_acc_tmr = (addr == {ADDR_WIDTH{1'b1}});
    assign w_rd_word = w_cur_tmr ? r_timer : r_mem[w_cur_idx];
`else
    assign w_acc_tmr = 1'b0;
    assign w_rd_word = r_mem[w_cur_idx];
`endif

    // Range check at full address width; one extra bit keeps DEPTH == 2^ADDR_WIDTH representable
    assign w_acc_err = (mem_rd & mem_wr) |
                       (({1'b0, addr} >= (ADDR_WIDTH+1)'(DEPTH)) & ~w_acc_tmr);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and detection of the RESP-entry edge
    always_comb begin
        w_next       = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_next       = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            WAIT: begin
                if (r_wcnt == 4'd0) begin
                    w_next       = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_next = WAIT;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the accept edge, so use live bus values there
    always_comb begin
        if (r_state == IDLE) begin
            w_cur_idx   = addr[IDXW-1:0];
            w_cur_wdata = data_in;
            w_cur_rd    = mem_rd;
            w_cur_err   = w_acc_err;
            w_cur_tmr   = w_acc_tmr;
        end else begin
            w_cur_idx   = r_idx;
            w_cur_wdata = r_wdata;
            w_cur_rd    = r_is_rd;
            w_cur_err   = r_is_err;
            w_cur_tmr   = r_is_tmr;
        end
    end

    // Request capture and wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt   <= 4'd0;
            r_idx    <= '0;
            r_wdata  <= 32'd0;
            r_is_rd  <= 1'b0;
            r_is_err <= 1'b0;
            r_is_tmr <= 1'b0;
        end else if (r_state == IDLE && w_req) begin
            r_wcnt   <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
            r_idx    <= addr[IDXW-1:0];
            r_wdata  <= data_in;
            r_is_rd  <= mem_rd;
            r_is_err <= w_acc_err;
            r_is_tmr <= w_acc_tmr;
        end else if (r_state == WAIT && r_wcnt != 4'd0) begin
            r_wcnt <= r_wcnt - 4'd1;
        end
    end

    // Array write on the RESP-entry edge; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_enter_resp && !w_cur_rd && !w_cur_err && !w_cur_tmr) begin
            r_mem[w_cur_idx] <= w_cur_wdata;
        end
    end

    // Registered response outputs, nonzero only during the single RESP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= 32'd0;
            r_oe       <= 1'b0;
            r_ready    <= 1'b0;
            r_err_o    <= 1'b0;
        end else begin
            r_ready    <= w_enter_resp;
            r_err_o    <= w_enter_resp & w_cur_err;
            r_oe       <= w_enter_resp & w_cur_rd & ~w_cur_err;
            r_data_out <= (w_enter_resp && w_cur_rd && !w_cur_err) ? w_rd_word : 32'd0;
        end
    end

    assign data_out  = r_data_out;
    assign oe_mem    = r_oe;
    assign mem_ready = r_ready;
    assign mem_err   = r_err_o;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with one wait state, one with zero.
module tb_mem_responder;

    localparam int WS_A = 1;

    typedef struct {
        logic [31:0] data;
        logic        oe;
        logic        err;
        bit          cd;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        a_rd, a_wr, b_rd, b_wr;
    logic [15:0] a_addr, b_addr;
    logic [31:0] a_din, b_din, a_dout, b_dout;
    logic        a_oe, a_ready, a_err, b_oe, b_ready, b_err;

    int          cyc;
    int          n_checks;
    int          n_errors;
    int          last_drive;
    logic [31:0] last_a;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        e_a, e_b;

    mem_responder #(.ADDR_WIDTH(16), .DEPTH(4096), .WAIT_STATES(WS_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mem_rd(a_rd), .mem_wr(a_wr), .addr(a_addr),
        .data_in(a_din), .data_out(a_dout), .oe_mem(a_oe), .mem_ready(a_ready), .mem_err(a_err)
    );

    mem_responder #(.ADDR_WIDTH(16), .DEPTH(4096), .WAIT_STATES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mem_rd(b_rd), .mem_wr(b_wr), .addr(b_addr),
        .data_in(b_din), .data_out(b_dout), .oe_mem(b_oe), .mem_ready(b_ready), .mem_err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ready) begin
                if (q_a.size() == 0) begin
                    chk("a_spurious_ready", 64'd1, 64'd0);
                end else begin
                    e_a    = q_a.pop_front();
                    last_a = a_dout;
                    if (e_a.cd) chk("a_data", {32'd0, a_dout}, {32'd0, e_a.data});
                    chk("a_oe", {63'd0, a_oe}, {63'd0, e_a.oe});
                    chk("a_err", {63'd0, a_err}, {63'd0, e_a.err});
                    chk("a_latency", 64'(cyc), 64'(e_a.cyc));
                end
            end else begin
                chk("a_idle_zero", {30'd0, a_oe, a_err, a_dout}, 64'd0);
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (rst_n) begin
            if (b_ready) begin
                if (q_b.size() == 0) begin
                    chk("b_spurious_ready", 64'd1, 64'd0);
                end else begin
                    e_b = q_b.pop_front();
                    if (e_b.cd) chk("b_data", {32'd0, b_dout}, {32'd0, e_b.data});
                    chk("b_oe", {63'd0, b_oe}, {63'd0, e_b.oe});
                    chk("b_err", {63'd0, b_err}, {63'd0, e_b.err});
                    chk("b_latency", 64'(cyc), 64'(e_b.cyc));
                end
            end else begin
                chk("b_idle_zero", {30'd0, b_oe, b_err, b_dout}, 64'd0);
            end
        end
    end

    task automatic wait_q_a();
        for (int i = 0; i < 20 && q_a.size() != 0; i++) @(negedge clk);
        if (q_a.size() != 0) begin
            chk("a_timeout", 64'(q_a.size()), 64'd0);
            q_a.delete();
        end
    endtask

    task automatic wait_q_b();
        for (int i = 0; i < 20 && q_b.size() != 0; i++) @(negedge clk);
        if (q_b.size() != 0) begin
            chk("b_timeout", 64'(q_b.size()), 64'd0);
            q_b.delete();
        end
    endtask

    task automatic txn_a(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d,
                         input logic [31:0] ed, input logic eoe, input logic eerr, input bit cd);
        exp_t e;
        @(negedge clk);
        a_rd = rd; a_wr = wr; a_addr = a; a_din = d;
        last_drive = cyc;
        e.data = ed; e.oe = eoe; e.err = eerr; e.cd = cd; e.cyc = cyc + WS_A + 1;
        q_a.push_back(e);
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0;
        wait_q_a();
    endtask

    initial begin
        exp_t        e;
        int          k;
        int          t0;
        logic [31:0] t1;
        logic [31:0] t2;
        cyc = 0; n_checks = 0; n_errors = 0; last_drive = 0; last_a = 32'd0;
        rst_n = 1'b0;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = 16'd0; a_din = 32'd0;
        b_rd = 1'b0; b_wr = 1'b0; b_addr = 16'd0; b_din = 32'd0;
        t0 = 0; t1 = 32'd0; t2 = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_a_outputs", {30'd0, a_oe, a_ready, a_err, a_dout[0]}, 64'd0);
        chk("reset_a_data", {32'd0, a_dout}, 64'd0);
        chk("reset_b_outputs", {30'd0, b_oe, b_ready, b_err, b_dout[0]}, 64'd0);
        rst_n = 1'b1;

        // Write then read back with one wait state
        txn_a(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 1'b1);
        txn_a(1'b1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);

        // Simultaneous rd/wr is an error and leaves the word untouched
        txn_a(1'b0, 1'b1, 16'h0020, 32'h00000055, 32'h0, 1'b0, 1'b0, 1'b1);
        txn_a(1'b1, 1'b1, 16'h0020, 32'h00000077, 32'h0, 1'b0, 1'b1, 1'b1);
        txn_a(1'b1, 1'b0, 16'h0020, 32'h0, 32'h00000055, 1'b1, 1'b0, 1'b1);

        // Out-of-range addresses, including one that would alias 0x0010 if truncated
        txn_a(1'b0, 1'b1, 16'h0FFF, 32'h13572468, 32'h0, 1'b0, 1'b0, 1'b1);
        txn_a(1'b0, 1'b1, 16'h1000, 32'h000000FF, 32'h0, 1'b0, 1'b1, 1'b1);
        txn_a(1'b1, 1'b0, 16'h1000, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        txn_a(1'b0, 1'b1, 16'h8010, 32'h0BADF00D, 32'h0, 1'b0, 1'b1, 1'b1);
        txn_a(1'b1, 1'b0, 16'h0FFF, 32'h0, 32'h13572468, 1'b1, 1'b0, 1'b1);
        txn_a(1'b1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);

`ifdef MEM_TIMER_EN
        // Counter reads ten cycles apart; an intervening write must not disturb it
        txn_a(1'b1, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        t0 = last_drive;
        t1 = last_a;
        txn_a(1'b0, 1'b1, 16'hFFFF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        while (cyc < t0 + 9) @(negedge clk);
        txn_a(1'b1, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        t2 = last_a;
        chk("timer_delta", {32'd0, t2 - t1}, 64'd10);
`else
        txn_a(1'b1, 1'b0, 16'hFFFF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
`endif

        // Zero wait states: write then read with the strobe held across RESP
        @(negedge clk);
        k = cyc;
        b_wr = 1'b1; b_addr = 16'h0000; b_din = 32'h00000001;
        e.data = 32'h0; e.oe = 1'b0; e.err = 1'b0; e.cd = 1'b1; e.cyc = k + 1;
        q_b.push_back(e);
        @(negedge clk);
        b_wr = 1'b0; b_rd = 1'b1;
        e.data = 32'h00000001; e.oe = 1'b1; e.err = 1'b0; e.cd = 1'b1; e.cyc = k + 3;
        q_b.push_back(e);
        @(negedge clk);
        @(negedge clk);
        b_rd = 1'b0;
        wait_q_b();

        // Reset during the WAIT cycle of a write aborts it without touching the array
        txn_a(1'b0, 1'b1, 16'h0030, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a_wr = 1'b1; a_addr = 16'h0030; a_din = 32'h12345678;
        @(negedge clk);
        a_wr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {30'd0, a_oe, a_ready, a_err, a_dout[0]}, 64'd0);
        chk("abort_data", {32'd0, a_dout}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        txn_a(1'b1, 1'b0, 16'h0030, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1);
        txn_a(1'b0, 1'b1, 16'h0031, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b1);
        txn_a(1'b1, 1'b0, 16'h0031, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        wait_q_a();
        wait_q_b();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
